// File: rtl/uart_rx_pkg.sv
// Shared types, default constants and helpers for the serial deframer.
// Optional feature macro used elsewhere: PARITY_CHECK_EN.
package uart_rx_pkg;

  typedef enum logic {HUNT, LOCKED} rx_state_t;

  localparam int              DEF_WORD_SIZE    = 27;
  localparam int              DEF_SYNC_BITS    = 8;
  localparam logic [7:0]      DEF_SYNC_PATTERN = 8'hA5;

  // True when the word holds an even number of ones. Callers zero-extend
  // narrower words, which leaves the ones count unchanged.
  function automatic logic even_parity_ok(input logic [63:0] word);
    return ~(^word);
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// MSB-first serial shift register with a saturating fill counter.
// sr_next is the word including the bit arriving this cycle; full says that
// word is made entirely of bits received since reset.
module serial_shift_reg
  import uart_rx_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 serial_in,
  output logic [WORD_SIZE-1:0] sr_next,
  output logic                 full
);

  localparam int            CW   = $clog2(WORD_SIZE + 1);
  localparam logic [CW-1:0] SAT  = CW'(WORD_SIZE);
  localparam logic [CW-1:0] LAST = CW'(WORD_SIZE - 1);

  logic [WORD_SIZE-1:0] sr_q, sr_d;
  logic [CW-1:0]        bits_seen_q, bits_seen_d;

  // Shift in the new bit and count fill up to saturation.
  always_comb begin
    sr_d        = {sr_q[WORD_SIZE-2:0], serial_in};
    bits_seen_d = (bits_seen_q == SAT) ? bits_seen_q : bits_seen_q + CW'(1);
  end

  assign sr_next = sr_d;
  assign full    = (bits_seen_q >= LAST);

  // Shift register and fill counter state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr_q        <= '0;
      bits_seen_q <= '0;
    end else begin
      sr_q        <= sr_d;
      bits_seen_q <= bits_seen_d;
    end
  end

endmodule

// File: rtl/serial_deframer.sv
// Serial word deframer: hunts for the sync header, then tracks word
// boundaries with a down-counter and strobes out each payload.
// Define PARITY_CHECK_EN to enable even-parity checking of accepted words.
//
// state  | meaning
// HUNT   | no alignment; test every bit position once the register is full
// LOCKED | aligned; test the header only when bit_counter reaches zero
module serial_deframer
  import uart_rx_pkg::*;
#(
  parameter int                   WORD_SIZE    = DEF_WORD_SIZE,
  parameter int                   SYNC_BITS    = DEF_SYNC_BITS,
  parameter logic [SYNC_BITS-1:0] SYNC_PATTERN = DEF_SYNC_PATTERN
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           serialIn,
  output logic [WORD_SIZE-SYNC_BITS-1:0] data_out,
  output logic                           data_valid,
  output logic                           locked,
  output logic                           sync_error,
  output logic                           parity_error
);

  localparam int            PW       = WORD_SIZE - SYNC_BITS;
  localparam int            CW       = $clog2(WORD_SIZE);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WORD_SIZE - 1);

  logic [WORD_SIZE-1:0] sr_next;
  logic                 full;
  logic                 header_ok;
  logic                 accept;

  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          locked_q, locked_d;
  logic          sync_err_q, sync_err_d;
`ifdef PARITY_CHECK_EN
  logic          par_err_q, par_err_d;
  logic          parity_ok;
`endif

  serial_shift_reg #(.WORD_SIZE(WORD_SIZE)) u_shift (
    .clock    (clock),
    .reset    (reset),
    .serial_in(serialIn),
    .sr_next  (sr_next),
    .full     (full)
  );

  assign header_ok = (sr_next[WORD_SIZE-1 -: SYNC_BITS] == SYNC_PATTERN);
`ifdef PARITY_CHECK_EN
  assign parity_ok = even_parity_ok(64'(sr_next));
`endif

  // Alignment FSM: decide on acceptance, loss of lock and output strobes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    locked_d   = locked_q;
    sync_err_d = 1'b0;
    accept     = 1'b0;
`ifdef PARITY_CHECK_EN
    par_err_d  = 1'b0;
`endif
    case (state_q)
      HUNT: begin
        if (full && header_ok) accept = 1'b1;
      end
      LOCKED: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          if (header_ok) begin
            accept = 1'b1;
          end else begin
            sync_err_d = 1'b1;
            locked_d   = 1'b0;
            cnt_d      = CNT_LOAD;
            state_d    = HUNT;
          end
        end
      end
    endcase
    if (accept) begin
      state_d  = LOCKED;
      locked_d = 1'b1;
      cnt_d    = CNT_LOAD;
`ifdef PARITY_CHECK_EN
      // A parity failure keeps alignment but withholds the payload.
      if (parity_ok) begin
        valid_d = 1'b1;
        data_d  = sr_next[PW-1:0];
      end else begin
        par_err_d = 1'b1;
      end
`else
      valid_d = 1'b1;
      data_d  = sr_next[PW-1:0];
`endif
    end
  end

  // FSM state, boundary counter and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      cnt_q      <= CNT_LOAD;
      data_q     <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      sync_err_q <= sync_err_d;
    end
  end

`ifdef PARITY_CHECK_EN
  // Parity error strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) par_err_q <= 1'b0;
    else       par_err_q <= par_err_d;
  end
  assign parity_error = par_err_q;
`else
  assign parity_error = 1'b0;
`endif

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign locked     = locked_q;
  assign sync_error = sync_err_q;

endmodule
